// File: rtl/collision_scan_controller.sv
// Per-frame collision sequencer: snapshots positions, scans ship/bullet vs alien
// pairs through one shared box comparator, and owns lives, score and win/lose state.
module collision_scan_controller #(
  parameter int unsigned N_BULLETS   = 10,
  parameter int unsigned N_ALIENS    = 10,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned HIT_R       = 4,
  parameter int unsigned SCORE_HIT   = 50,
  parameter int unsigned WIN_SCORE   = 1000,
  parameter int unsigned START_LIVES = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           frame_tick,
  input  logic [COORD_W-1:0]             ship_x,
  input  logic [COORD_W-1:0]             ship_y,
  input  logic [N_BULLETS*COORD_W-1:0]   bullet_x,
  input  logic [N_BULLETS*COORD_W-1:0]   bullet_y,
  input  logic [N_BULLETS-1:0]           bullet_active,
  input  logic [N_ALIENS*COORD_W-1:0]    alien_x,
  input  logic [N_ALIENS*COORD_W-1:0]    alien_y,
  input  logic [N_ALIENS-1:0]            alien_active,
  output logic [N_BULLETS-1:0]           bullet_kill,
  output logic [N_ALIENS-1:0]            alien_kill,
  output logic                           ship_hit,
  output logic                           frame_done,
  output logic                           frame_overrun,
  output logic                           scan_busy,
  output logic [2:0]                     lives,
  output logic [9:0]                     score,
  output logic                           game_over,
  output logic                           you_won
);

  localparam int unsigned AW      = (N_ALIENS  > 1) ? $clog2(N_ALIENS)  : 1;
  localparam int unsigned BW      = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
  localparam int unsigned SCORE_W = 10;
  localparam int unsigned LIVES_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY, S_SNAP, S_SHIP, S_BULLET, S_RESOLVE, S_OVER
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        a_q, a_d;
  logic [BW-1:0]        b_q, b_d;
  logic [COORD_W-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic [COORD_W-1:0]   bx_q [N_BULLETS];
  logic [COORD_W-1:0]   bx_d [N_BULLETS];
  logic [COORD_W-1:0]   by_q [N_BULLETS];
  logic [COORD_W-1:0]   by_d [N_BULLETS];
  logic [COORD_W-1:0]   ax_q [N_ALIENS];
  logic [COORD_W-1:0]   ax_d [N_ALIENS];
  logic [COORD_W-1:0]   ay_q [N_ALIENS];
  logic [COORD_W-1:0]   ay_d [N_ALIENS];
  logic [N_BULLETS-1:0] bact_q, bact_d, bk_q, bk_d;
  logic [N_ALIENS-1:0]  aact_q, aact_d, ak_q, ak_d;
  logic                 ship_flag_q, ship_flag_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 won_q, won_d;
  logic [N_BULLETS-1:0] bullet_kill_q, bullet_kill_d;
  logic [N_ALIENS-1:0]  alien_kill_q, alien_kill_d;
  logic                 ship_hit_q, ship_hit_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_overrun_q, frame_overrun_d;
  logic                 scan_busy_q, scan_busy_d;
  logic                 game_over_q, game_over_d;

  logic [COORD_W-1:0]   cmp_x, cmp_y, tgt_x, tgt_y;
  logic                 hit_c;
  logic                 adv_b;
  logic [SCORE_W:0]     score_sum;

  // Distance is taken as larger minus smaller, one bit wider, so the playfield never wraps.
  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] p,
                                                input logic [COORD_W-1:0] q);
    if (p >= q) abs_diff = {1'b0, p} - {1'b0, q};
    else        abs_diff = {1'b0, q} - {1'b0, p};
  endfunction

  // Shared box comparator: ship in SHIP, current bullet otherwise, against alien a.
  always_comb begin
    tgt_x = ax_q[a_q];
    tgt_y = ay_q[a_q];
    cmp_x = (state_q == S_SHIP) ? sx_q : bx_q[b_q];
    cmp_y = (state_q == S_SHIP) ? sy_q : by_q[b_q];
    hit_c = (abs_diff(cmp_x, tgt_x) <= (COORD_W+1)'(HIT_R)) &&
            (abs_diff(cmp_y, tgt_y) <= (COORD_W+1)'(HIT_R));
  end

  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(SCORE_HIT);

  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    b_d             = b_q;
    sx_d            = sx_q;
    sy_d            = sy_q;
    bx_d            = bx_q;
    by_d            = by_q;
    ax_d            = ax_q;
    ay_d            = ay_q;
    bact_d          = bact_q;
    aact_d          = aact_q;
    bk_d            = bk_q;
    ak_d            = ak_q;
    ship_flag_d     = ship_flag_q;
    lives_d         = lives_q;
    score_d         = score_q;
    won_d           = won_q;
    bullet_kill_d   = '0;
    alien_kill_d    = '0;
    ship_hit_d      = 1'b0;
    frame_done_d    = 1'b0;
    frame_overrun_d = 1'b0;
    adv_b           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (frame_tick) state_d = S_SNAP;
      end
      S_SNAP: begin
        sx_d   = ship_x;
        sy_d   = ship_y;
        bact_d = bullet_active;
        aact_d = alien_active;
        for (int i = 0; i < N_BULLETS; i++) begin
          bx_d[i] = bullet_x[i*COORD_W +: COORD_W];
          by_d[i] = bullet_y[i*COORD_W +: COORD_W];
        end
        for (int i = 0; i < N_ALIENS; i++) begin
          ax_d[i] = alien_x[i*COORD_W +: COORD_W];
          ay_d[i] = alien_y[i*COORD_W +: COORD_W];
        end
        bk_d        = '0;
        ak_d        = '0;
        ship_flag_d = 1'b0;
        a_d         = '0;
        b_d         = '0;
        state_d     = S_SHIP;
      end
      S_SHIP: begin
        // The first ship hit ends the ship scan, so at most one life goes per frame.
        if (aact_q[a_q] && hit_c) begin
          ak_d[a_q]   = 1'b1;
          ship_flag_d = 1'b1;
          a_d         = '0;
          state_d     = S_BULLET;
        end else if (a_q == AW'(N_ALIENS-1)) begin
          a_d     = '0;
          state_d = S_BULLET;
        end else begin
          a_d = a_q + AW'(1);
        end
      end
      S_BULLET: begin
        if (!bact_q[b_q]) begin
          adv_b = 1'b1;
        end else if (aact_q[a_q] && !ak_q[a_q] && hit_c) begin
          bk_d[b_q] = 1'b1;
          ak_d[a_q] = 1'b1;
          score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          adv_b     = 1'b1;
        end else if (a_q == AW'(N_ALIENS-1)) begin
          adv_b = 1'b1;
        end else begin
          a_d = a_q + AW'(1);
        end
        if (adv_b) begin
          a_d = '0;
          if (b_q == BW'(N_BULLETS-1)) state_d = S_RESOLVE;
          else                         b_d     = b_q + BW'(1);
        end
      end
      S_RESOLVE: begin
        if (ship_flag_q && (lives_q != '0)) lives_d = lives_q - LIVES_W'(1);
        // Losing the last life outranks reaching the win score in the same frame.
        if (lives_d == '0) begin
          state_d = S_OVER;
          won_d   = 1'b0;
        end else if (score_q >= SCORE_W'(WIN_SCORE)) begin
          state_d = S_OVER;
          won_d   = 1'b1;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_OVER: begin
        if (start) begin
          lives_d = LIVES_W'(START_LIVES);
          score_d = '0;
          won_d   = 1'b0;
          state_d = S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_tick && (state_q == S_SNAP || state_q == S_SHIP ||
                       state_q == S_BULLET || state_q == S_RESOLVE)) begin
      frame_overrun_d = 1'b1;
    end

    // Result pulses are loaded on entry so they are visible during the RESOLVE cycle.
    if (state_d == S_RESOLVE) begin
      bullet_kill_d = bk_d;
      alien_kill_d  = ak_d;
      ship_hit_d    = ship_flag_d;
      frame_done_d  = 1'b1;
    end

    scan_busy_d = (state_d == S_SNAP) || (state_d == S_SHIP) ||
                  (state_d == S_BULLET) || (state_d == S_RESOLVE);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      a_q             <= '0;
      b_q             <= '0;
      sx_q            <= '0;
      sy_q            <= '0;
      for (int i = 0; i < N_BULLETS; i++) begin
        bx_q[i] <= '0;
        by_q[i] <= '0;
      end
      for (int i = 0; i < N_ALIENS; i++) begin
        ax_q[i] <= '0;
        ay_q[i] <= '0;
      end
      bact_q          <= '0;
      aact_q          <= '0;
      bk_q            <= '0;
      ak_q            <= '0;
      ship_flag_q     <= 1'b0;
      lives_q         <= LIVES_W'(START_LIVES);
      score_q         <= '0;
      won_q           <= 1'b0;
      bullet_kill_q   <= '0;
      alien_kill_q    <= '0;
      ship_hit_q      <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
      scan_busy_q     <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      a_q             <= a_d;
      b_q             <= b_d;
      sx_q            <= sx_d;
      sy_q            <= sy_d;
      bx_q            <= bx_d;
      by_q            <= by_d;
      ax_q            <= ax_d;
      ay_q            <= ay_d;
      bact_q          <= bact_d;
      aact_q          <= aact_d;
      bk_q            <= bk_d;
      ak_q            <= ak_d;
      ship_flag_q     <= ship_flag_d;
      lives_q         <= lives_d;
      score_q         <= score_d;
      won_q           <= won_d;
      bullet_kill_q   <= bullet_kill_d;
      alien_kill_q    <= alien_kill_d;
      ship_hit_q      <= ship_hit_d;
      frame_done_q    <= frame_done_d;
      frame_overrun_q <= frame_overrun_d;
      scan_busy_q     <= scan_busy_d;
      game_over_q     <= game_over_d;
    end
  end

  assign bullet_kill   = bullet_kill_q;
  assign alien_kill    = alien_kill_q;
  assign ship_hit      = ship_hit_q;
  assign frame_done    = frame_done_q;
  assign frame_overrun = frame_overrun_q;
  assign scan_busy     = scan_busy_q;
  assign lives         = lives_q;
  assign score         = score_q;
  assign game_over     = game_over_q;
  assign you_won       = won_q;

endmodule
